gmm_view_mode_ctrl: RTL and testbench

Controller that drives the 2-bit display-mode select of the GMM foreground visor stage. It debounces a user push-button and optionally auto-cycles modes every N frames. It monitors the visor's input Avalon-ST handshake and applies a new mode only at the start of a video packet, so a frame is never rendered with mixed modes. It also exports a completed-video-frame counter for debug and status.

---
 rtl/gmm_view_mode_ctrl.sv | 150 +++++++++++++++
 tb/tb_gmm_view_mode_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmm_view_mode_ctrl.sv
// gmm_view_mode_ctrl: display-mode select for the GMM foreground visor.
// Button/auto requests are applied only on a video SOP beat.
module gmm_view_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_FRAMES     = 0,
    parameter int NUM_MODES       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_n,
    input  logic        auto_en,
    input  logic        mon_valid,
    input  logic        mon_ready,
    input  logic        mon_sop,
    input  logic        mon_eop,
    input  logic [3:0]  mon_type,
    output logic [1:0]  sw,
    output logic        pending,
    output logic [15:0] frame_cnt
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam int AFW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AFW-1:0] AF_LAST =
        AFW'((AUTO_FRAMES > 0) ? AUTO_FRAMES - 1 : 0);
    localparam logic [1:0] MODE_LAST = 2'(NUM_MODES - 1);
    localparam logic       AUTO_ON   = (AUTO_FRAMES > 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VIDEO,
        ST_OTHER
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic [DBW-1:0]   r_db_cnt;
    logic [AFW-1:0]   r_auto_cnt;
    logic [1:0]       r_req;
    logic [1:0]       r_sw;
    logic             r_pending;
    logic [15:0]      r_frame_cnt;

    logic             w_sop_beat;
    logic             w_eop_beat;
    logic             w_vid_sop;
    logic             w_frame_done;
    logic             w_db_hit;
    logic             w_press;
    logic             w_auto_on;
    logic             w_auto_adv;
    logic             w_adv;
    logic [1:0]       w_req_nxt;

    assign w_sop_beat = mon_valid & mon_ready & mon_sop;
    assign w_eop_beat = mon_valid & mon_ready & mon_eop;
    assign w_vid_sop  = w_sop_beat & (mon_type == 4'd0);

    // A level change is accepted on its DEBOUNCE_CYCLES-th stable cycle.
    assign w_db_hit   = (r_sync2 != r_deb) && (r_db_cnt == DB_LAST);
    assign w_press    = w_db_hit & r_deb;

    assign w_auto_on  = AUTO_ON & auto_en;
    assign w_auto_adv = w_auto_on & w_frame_done & (r_auto_cnt == AF_LAST);
    assign w_adv      = w_press | w_auto_adv;
    assign w_req_nxt  = (r_req == MODE_LAST) ? 2'd0 : r_req + 2'd1;

    // A SOP beat always starts a new packet, discarding any open one.
    always_comb begin
        w_state_nxt  = r_state;
        w_frame_done = 1'b0;
        if (w_sop_beat) begin
            if (mon_eop) begin
                w_state_nxt  = ST_IDLE;
                w_frame_done = (mon_type == 4'd0);
            end else if (mon_type == 4'd0) begin
                w_state_nxt = ST_VIDEO;
            end else begin
                w_state_nxt = ST_OTHER;
            end
        end else if (w_eop_beat) begin
            w_state_nxt  = ST_IDLE;
            w_frame_done = (r_state == ST_VIDEO);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_deb    <= 1'b1;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_deb) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_deb    <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DBW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_auto_cnt  <= '0;
            r_req       <= 2'd0;
            r_sw        <= 2'd0;
            r_pending   <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            if (!w_auto_on) begin
                r_auto_cnt <= '0;
            end else if (w_frame_done) begin
                r_auto_cnt <= (r_auto_cnt == AF_LAST) ? '0
                            : r_auto_cnt + AFW'(1);
            end
            if (w_adv) begin
                r_req <= w_req_nxt;
            end
            if (w_vid_sop) begin
                r_sw <= r_req;
            end
            r_pending <= (r_req != r_sw);
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign sw        = r_sw;
    assign pending   = r_pending;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_gmm_view_mode_ctrl.sv
// tb_gmm_view_mode_ctrl: directed and random stimulus checked against
// a window-based behavioural model of the mode controller.
module tb_gmm_view_mode_ctrl;

    localparam int D  = 4;
    localparam int AF = 2;
    localparam int NM = 3;

    logic        clk;
    logic        rst;
    logic        btn_n;
    logic        auto_en;
    logic        mon_valid;
    logic        mon_ready;
    logic        mon_sop;
    logic        mon_eop;
    logic [3:0]  mon_type;
    logic [1:0]  sw;
    logic        pending;
    logic [15:0] frame_cnt;

    gmm_view_mode_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .AUTO_FRAMES     (AF),
        .NUM_MODES       (NM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_n     (btn_n),
        .auto_en   (auto_en),
        .mon_valid (mon_valid),
        .mon_ready (mon_ready),
        .mon_sop   (mon_sop),
        .mon_eop   (mon_eop),
        .mon_type  (mon_type),
        .sw        (sw),
        .pending   (pending),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_on  = 1'b1;

    // model: last D raw button samples, accepted level, press delay line
    logic [D-1:0] m_hist;
    logic         m_acc;
    logic         m_pp0;
    logic         m_pp1;
    logic [1:0]   m_req;
    logic [1:0]   m_sw;
    logic         m_pend;
    logic [15:0]  m_fc;
    int           m_afc;
    int           m_pkt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist = '1;
        m_acc  = 1'b1;
        m_pp0  = 1'b0;
        m_pp1  = 1'b0;
        m_req  = 2'd0;
        m_sw   = 2'd0;
        m_pend = 1'b0;
        m_fc   = 16'd0;
        m_afc  = 0;
        m_pkt  = 0;
    endtask

    task automatic model_step();
        bit       press;
        bit       done;
        bit       aadv;
        bit       beat;
        logic [1:0] old_req;
        old_req = m_req;
        m_pend  = (m_req != m_sw);
        press   = m_pp1;
        m_pp1   = m_pp0;
        m_pp0   = 1'b0;
        m_hist  = {m_hist[D-2:0], btn_n};
        if (m_hist == '0 && m_acc) begin
            m_acc = 1'b0;
            m_pp0 = 1'b1;
        end else if (m_hist == '1 && !m_acc) begin
            m_acc = 1'b1;
        end
        done = 1'b0;
        aadv = 1'b0;
        beat = mon_valid && mon_ready;
        if (beat && mon_sop) begin
            if (mon_type == 4'd0) m_sw = old_req;
            if (mon_eop) begin
                done  = (mon_type == 4'd0);
                m_pkt = 0;
            end else begin
                m_pkt = (mon_type == 4'd0) ? 1 : 2;
            end
        end else if (beat && mon_eop) begin
            done  = (m_pkt == 1);
            m_pkt = 0;
        end
        if (done) m_fc = m_fc + 16'd1;
        if (auto_en) begin
            if (done) begin
                m_afc++;
                if (m_afc == AF) begin
                    m_afc = 0;
                    aadv  = 1'b1;
                end
            end
        end else begin
            m_afc = 0;
        end
        if (press || aadv) m_req = 2'((int'(old_req) + 1) % NM);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (chk_on) begin
            chk("sw", 32'(sw), 32'(m_sw));
            chk("pending", 32'(pending), 32'(m_pend));
            chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
        end
    endtask

    task automatic bt(input logic s, input logic e, input logic [3:0] t);
        mon_valid = 1'b1;
        mon_ready = 1'b1;
        mon_sop   = s;
        mon_eop   = e;
        mon_type  = t;
        tick();
    endtask

    task automatic idle(input int n);
        mon_valid = 1'b0;
        mon_sop   = 1'b0;
        mon_eop   = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_btn();
        btn_n = 1'b0;
        idle(6);
        btn_n = 1'b1;
        idle(8);
    endtask

    task automatic frame(input int ndata);
        bt(1'b1, 1'b0, 4'h0);
        for (int i = 0; i < ndata; i++) bt(1'b0, 1'b0, 4'h0);
        bt(1'b0, 1'b1, 4'h0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  exp_sw [5];
        logic [1:0]  sw6;
        logic [15:0] fc0;
        int          run_left;
        exp_sw = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd1};
        rst       = 1'b1;
        btn_n     = 1'b1;
        auto_en   = 1'b0;
        mon_valid = 1'b0;
        mon_ready = 1'b0;
        mon_sop   = 1'b0;
        mon_eop   = 1'b0;
        mon_type  = 4'h0;
        model_reset();
        #12;
        chk("rst_sw", 32'(sw), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        #1 rst = 1'b0;

        // long press, then one video packet
        btn_n = 1'b0;
        idle(10);
        chk("t1_pend_up", 32'(pending), 32'd1);
        btn_n = 1'b1;
        idle(10);
        bt(1'b1, 1'b0, 4'h0);
        chk("t1_sw_sop", 32'(sw), 32'd1);
        bt(1'b0, 1'b0, 4'h0);
        chk("t1_pend_down", 32'(pending), 32'd0);
        bt(1'b0, 1'b0, 4'h0);
        bt(1'b0, 1'b0, 4'h0);
        bt(1'b0, 1'b1, 4'h0);
        chk("t1_frames", 32'(frame_cnt), 32'd1);

        // short glitch is rejected
        btn_n = 1'b0;
        idle(2);
        btn_n = 1'b1;
        idle(10);
        chk("t2_sw", 32'(sw), 32'd1);
        chk("t2_pend", 32'(pending), 32'd0);

        // press mid-frame waits for the next video SOP
        bt(1'b1, 1'b0, 4'h0);
        btn_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bt(1'b0, 1'b0, 4'h0);
            chk("t3_sw_mid", 32'(sw), 32'd1);
        end
        btn_n = 1'b1;
        for (int i = 0; i < 6; i++) bt(1'b0, 1'b0, 4'h0);
        bt(1'b0, 1'b1, 4'h0);
        chk("t3_pend_eop", 32'(pending), 32'd1);
        bt(1'b1, 1'b0, 4'hF);
        bt(1'b0, 1'b0, 4'hF);
        bt(1'b0, 1'b1, 4'hF);
        chk("t3_sw_ctrl", 32'(sw), 32'd1);
        bt(1'b1, 1'b0, 4'h0);
        chk("t3_sw_vid", 32'(sw), 32'd2);
        bt(1'b0, 1'b1, 4'h0);

        // NUM_MODES presses return to the applied mode
        for (int p = 0; p < 3; p++) press_btn();
        chk("t4_pend", 32'(pending), 32'd0);
        chk("t4_sw", 32'(sw), 32'd2);

        // auto-cycle every 2 frames
        auto_en = 1'b1;
        for (int f = 0; f < 5; f++) begin
            bt(1'b1, 1'b0, 4'h0);
            chk("t5_sw_auto", 32'(sw), 32'(exp_sw[f]));
            bt(1'b0, 1'b0, 4'h0);
            bt(1'b0, 1'b1, 4'h0);
        end
        // press lands on the same edge as the auto advance
        btn_n = 1'b0;
        bt(1'b1, 1'b0, 4'h0);
        sw6 = sw;
        for (int i = 0; i < D; i++) bt(1'b0, 1'b0, 4'h0);
        bt(1'b0, 1'b1, 4'h0);
        btn_n = 1'b1;
        idle(8);
        bt(1'b1, 1'b0, 4'h0);
        chk("t5_sw6", 32'(sw6), 32'd1);
        chk("t5_single_adv", 32'(sw), 32'd2);
        bt(1'b0, 1'b1, 4'h0);
        auto_en = 1'b0;

        // lost EOP: aborted packet does not count
        fc0 = m_fc;
        bt(1'b1, 1'b0, 4'h0);
        bt(1'b0, 1'b0, 4'h0);
        bt(1'b0, 1'b0, 4'h0);
        bt(1'b1, 1'b0, 4'h0);
        bt(1'b0, 1'b0, 4'h0);
        bt(1'b0, 1'b1, 4'h0);
        chk("t6_lost_eop", 32'(frame_cnt), 32'(fc0 + 16'd1));

        // random traffic and button activity
        run_left = 0;
        for (int c = 0; c < 4000; c++) begin
            int r;
            if (c % 500 == 0) auto_en = 1'($urandom_range(0, 1));
            if (run_left == 0) begin
                btn_n    = ~btn_n;
                run_left = ($urandom_range(0, 1) == 1)
                         ? int'($urandom_range(1, 3))
                         : int'($urandom_range(5, 12));
            end
            run_left--;
            r = int'($urandom_range(0, 3));
            mon_valid = ($urandom_range(0, 3) != 0);
            mon_ready = ($urandom_range(0, 3) != 0);
            mon_sop   = ($urandom_range(0, 5) == 0);
            mon_eop   = ($urandom_range(0, 4) == 0);
            mon_type  = (r < 2) ? 4'h0 : (r == 2) ? 4'hF : 4'h3;
            tick();
        end
        btn_n   = 1'b1;
        auto_en = 1'b0;
        idle(10);

        // run single-beat frames up to the counter wrap
        chk_on = 1'b0;
        for (int i = 0; i < 70000 && m_fc != 16'hFFFF; i++) begin
            bt(1'b1, 1'b1, 4'h0);
        end
        chk_on = 1'b1;
        idle(1);
        chk("pre_wrap", 32'(frame_cnt), 32'hFFFF);
        bt(1'b1, 1'b1, 4'h0);
        chk("wrap", 32'(frame_cnt), 32'h0);

        // reset in the middle of a packet
        press_btn();
        frame(1);
        bt(1'b1, 1'b0, 4'h0);
        bt(1'b0, 1'b0, 4'h0);
        rst = 1'b1;
        #2;
        chk("mid_rst_sw", 32'(sw), 32'd0);
        chk("mid_rst_pending", 32'(pending), 32'd0);
        chk("mid_rst_frames", 32'(frame_cnt), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        bt(1'b0, 1'b0, 4'h0);
        bt(1'b0, 1'b1, 4'h0);
        chk("post_rst_orphan_eop", 32'(frame_cnt), 32'd0);
        frame(2);
        chk("post_rst_frame", 32'(frame_cnt), 32'd1);
        chk("post_rst_sw", 32'(sw), 32'd0);
        idle(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
